pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL expose parameter PLL_RST_CYCLES, default 16: number of cycles pll_rst is held high per reset attempt (min 2).
REQ-002 SHALL expose parameter LOCK_TIMEOUT, default 742500: cycles allowed for lock after pll_rst release (10 ms at 74.25 MHz).
REQ-003 SHALL expose parameter STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before release.
REQ-004 clk_74a  input  1  free-running 74.25 MHz reference clock, the only clock in the block.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 pll_locked  input  1  PLL lock indicator, asynchronous to clk_74a.
REQ-007 relock_req  input  1  single-cycle synchronous request to force a full PLL re-lock.
REQ-008 pll_rst  output  1  active-high reset to the PLL.
REQ-009 core_reset_n  output  1  active-low reset for logic clocked by the PLL outputs.
REQ-010 pll_ready  output  1  high only while in RUN.
REQ-011 lock_lost  output  1  one-cycle pulse when lock drops during RUN.
REQ-012 timeout_err  output  1  one-cycle pulse when a lock attempt times out.
REQ-013 retry_count  output  4  saturating count of timeouts plus lock losses since reset.

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchronizer (locked_s); all decisions use locked_s only, giving 2-cycle input latency.
REQ-015 FSM states SHALL be PLL_RST, WAIT_LOCK, STABILIZE, RUN.
REQ-016 PLL_RST: pll_rst=1; after exactly PLL_RST_CYCLES cycles in state -> WAIT_LOCK, counter cleared.
REQ-017 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABILIZE; else after LOCK_TIMEOUT cycles -> PLL_RST with timeout_err pulse and retry_count+1.
REQ-018 STABILIZE: locked_s=0 -> WAIT_LOCK with timeout counter restarted; STABLE_CYCLES consecutive locked_s=1 cycles -> RUN.
REQ-019 RUN: core_reset_n=1, pll_ready=1; locked_s=0 -> PLL_RST with lock_lost pulse and retry_count+1.
REQ-020 relock_req=1 in any state SHALL force PLL_RST next cycle with counter cleared, no pulse, no retry_count change; it overrides every other transition in that cycle.
REQ-021 All outputs SHALL be registered and decoded from next state: core_reset_n/pll_ready rise in the cycle the FSM enters RUN and fall in the cycle it leaves.
REQ-022 retry_count SHALL saturate at 15 and never wrap.
REQ-023 A single counter, width ceil(log2(max of the three parameters))+1, SHALL be shared by all timed states and cleared on every state change.
REQ-024 locked_s glitch of one cycle in STABILIZE SHALL restart the stability count; in RUN it SHALL trigger lock loss (no filtering).

Reset
REQ-025 On reset_n low: state PLL_RST, pll_rst=1, core_reset_n=0, pll_ready=0, lock_lost=0, timeout_err=0, retry_count=0, counter=0, synchronizer flops 0.
REQ-026 Reset assertion SHALL take effect asynchronously mid-operation; deassertion SHALL restart the full PLL_RST sequence.

Structure
REQ-027 State enum and default parameter constants SHALL live in shared package pll_sup_pkg.
REQ-028 The synchronizer SHALL be sub-module sync_2ff (1-bit, async active-low reset), reusable elsewhere in the core.

Verification (PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8)
REQ-029 Normal: release reset, raise pll_locked 3 cycles after pll_rst falls -> pll_rst high exactly 4 cycles, core_reset_n rises 2+8 cycles after locked_s path entry, retry_count=0.
REQ-030 Timeout: pll_locked held 0 -> timeout_err pulses 20 cycles after pll_rst falls, pll_rst high again 4 cycles, retry_count increments each attempt and stops at 15.
REQ-031 Lock loss: in RUN drop pll_locked 1 cycle -> lock_lost pulse, core_reset_n=0 and pll_rst=1 on the same cycle, retry_count+1.
REQ-032 Unstable lock: toggle pll_locked low after 5 locked cycles in STABILIZE -> returns to WAIT_LOCK, core_reset_n stays 0, full 8 cycles required afterwards.
REQ-033 relock_req coincident with a timeout in WAIT_LOCK -> PLL_RST, no timeout_err, retry_count unchanged.
REQ-034 Assert reset_n low mid-RUN -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// Shared types and default timing constants for the PLL lock supervisor.
// Defaults assume a 74.25 MHz reference clock.
package pll_sup_pkg;

    typedef enum logic [1:0] {
        StPllRst,
        StWaitLock,
        StStabilize,
        StRun
    } pll_state_e;

    localparam int unsigned PllRstCyclesDef = 16;
    localparam int unsigned LockTimeoutDef  = 742500;
    localparam int unsigned StableCyclesDef = 1024;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit asynchronous level signal.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for a stable lock, and holds the PLL-domain logic in reset
// until then. Lock timeouts and lock losses restart the sequence and are counted.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = PllRstCyclesDef,
    parameter int unsigned LOCK_TIMEOUT   = LockTimeoutDef,
    parameter int unsigned STABLE_CYCLES  = StableCyclesDef
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       core_reset_n,
    output logic       pll_ready,
    output logic       lock_lost,
    output logic       timeout_err,
    output logic [3:0] retry_count
);

    localparam int unsigned CntW = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;
    localparam logic [CntW-1:0] RstLast     = CntW'(PLL_RST_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);

    logic            locked_s;
    pll_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_ev, lost_ev;

    logic       pll_rst_q, pll_rst_d;
    logic       core_reset_n_q, core_reset_n_d;
    logic       pll_ready_q, pll_ready_d;
    logic       lock_lost_q, lock_lost_d;
    logic       timeout_err_q, timeout_err_d;
    logic [3:0] retry_q, retry_d;

    sync_2ff u_lock_sync (
        .clk_i  (clk_74a),
        .rst_ni (reset_n),
        .d_i    (pll_locked),
        .q_o    (locked_s)
    );

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StPllRst;
            cnt_q          <= '0;
            pll_rst_q      <= 1'b1;
            core_reset_n_q <= 1'b0;
            pll_ready_q    <= 1'b0;
            lock_lost_q    <= 1'b0;
            timeout_err_q  <= 1'b0;
            retry_q        <= 4'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pll_rst_q      <= pll_rst_d;
            core_reset_n_q <= core_reset_n_d;
            pll_ready_q    <= pll_ready_d;
            lock_lost_q    <= lock_lost_d;
            timeout_err_q  <= timeout_err_d;
            retry_q        <= retry_d;
        end
    end

    // relock_req wins over every other transition and suppresses the event pulses.
    always_comb begin
        state_d    = state_q;
        timeout_ev = 1'b0;
        lost_ev    = 1'b0;
        if (relock_req) begin
            state_d = StPllRst;
        end else begin
            case (state_q)
                StPllRst: begin
                    if (cnt_q == RstLast) state_d = StWaitLock;
                end
                StWaitLock: begin
                    if (locked_s) begin
                        state_d = StStabilize;
                    end else if (cnt_q == TimeoutLast) begin
                        state_d    = StPllRst;
                        timeout_ev = 1'b1;
                    end
                end
                StStabilize: begin
                    if (!locked_s) begin
                        state_d = StWaitLock;
                    end else if (cnt_q == StableLast) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (!locked_s) begin
                        state_d = StPllRst;
                        lost_ev = 1'b1;
                    end
                end
                default: state_d = StPllRst;
            endcase
        end

        // RUN is untimed, so the counter holds there instead of wrapping.
        if (relock_req || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (state_q == StRun) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        pll_rst_d      = (state_d == StPllRst);
        core_reset_n_d = (state_d == StRun);
        pll_ready_d    = (state_d == StRun);
        lock_lost_d    = lost_ev;
        timeout_err_d  = timeout_ev;
        retry_d        = retry_q;
        if ((timeout_ev || lost_ev) && (retry_q != 4'hF)) begin
            retry_d = retry_q + 4'd1;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign core_reset_n = core_reset_n_q;
    assign pll_ready    = pll_ready_q;
    assign lock_lost    = lock_lost_q;
    assign timeout_err  = timeout_err_q;
    assign retry_count  = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters (4/20/8).
module tb_pll_lock_supervisor;

    logic       clk_74a;
    logic       reset_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       core_reset_n;
    logic       pll_ready;
    logic       lock_lost;
    logic       timeout_err;
    logic [3:0] retry_count;

    int n_total;
    int n_bad;
    int exp_retry;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8)
    ) dut (
        .clk_74a      (clk_74a),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .relock_req   (relock_req),
        .pll_rst      (pll_rst),
        .core_reset_n (core_reset_n),
        .pll_ready    (pll_ready),
        .lock_lost    (lock_lost),
        .timeout_err  (timeout_err),
        .retry_count  (retry_count)
    );

    initial clk_74a = 1'b0;
    always #5 clk_74a = ~clk_74a;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk_74a);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_pll_rst"}, 32'(pll_rst), 1);
        check_val({tag, "_core_reset_n"}, 32'(core_reset_n), 0);
        check_val({tag, "_pll_ready"}, 32'(pll_ready), 0);
        check_val({tag, "_lock_lost"}, 32'(lock_lost), 0);
        check_val({tag, "_timeout_err"}, 32'(timeout_err), 0);
        check_val({tag, "_retry"}, 32'(retry_count), 0);
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        tick(3);
        check_reset_outputs("rst");

        // Normal bring-up: reset released just after edge 0.
        reset_n = 1'b1;
        tick(3);
        check_val("rst_hold_e3", 32'(pll_rst), 1);
        tick(1);
        check_val("rst_fall_e4", 32'(pll_rst), 0);
        tick(3);
        pll_locked = 1'b1;              // edge 7; locked_s at 9, STABILIZE at 10, RUN at 18
        tick(10);
        check_val("run_pre_core", 32'(core_reset_n), 0);
        check_val("run_pre_ready", 32'(pll_ready), 0);
        tick(1);
        check_val("run_core", 32'(core_reset_n), 1);
        check_val("run_ready", 32'(pll_ready), 1);
        check_val("run_pll_rst", 32'(pll_rst), 0);
        check_val("run_retry", 32'(retry_count), 0);

        // One-cycle lock drop in RUN: low after edge 20, back after 21, seen at edge 23.
        tick(2);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(1);
        check_val("loss_pre_core", 32'(core_reset_n), 1);
        check_val("loss_pre_pulse", 32'(lock_lost), 0);
        tick(1);
        check_val("loss_pulse", 32'(lock_lost), 1);
        check_val("loss_core", 32'(core_reset_n), 0);
        check_val("loss_ready", 32'(pll_ready), 0);
        check_val("loss_pll_rst", 32'(pll_rst), 1);
        check_val("loss_retry", 32'(retry_count), 1);
        tick(1);
        check_val("loss_pulse_end", 32'(lock_lost), 0);

        // Re-lock: WAIT_LOCK at 27, STABILIZE at 28; glitch after 5 stable cycles.
        tick(7);
        check_val("unst_pll_rst", 32'(pll_rst), 0);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(2);
        check_val("unst_core_e34", 32'(core_reset_n), 0);
        tick(8);
        check_val("unst_core_e42", 32'(core_reset_n), 0);
        tick(1);
        check_val("unst_core_e43", 32'(core_reset_n), 1);
        check_val("unst_retry", 32'(retry_count), 1);

        // Asynchronous reset mid-RUN, between clock edges.
        tick(2);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async");
        pll_locked = 1'b0;
        tick(2);
        check_reset_outputs("async_held");

        // Timeouts with pll_locked held low; attempt 3 hits relock_req on the timeout edge.
        reset_n = 1'b1;
        exp_retry = 0;
        tick(4);
        check_val("to_first_fall", 32'(pll_rst), 0);
        for (int att = 1; att <= 18; att++) begin
            tick(19);
            check_val("to_pre_pulse", 32'(timeout_err), 0);
            check_val("to_pre_pll_rst", 32'(pll_rst), 0);
            if (att == 3) relock_req = 1'b1;
            tick(1);
            if (att == 3) begin
                relock_req = 1'b0;
                check_val("relock_no_pulse", 32'(timeout_err), 0);
            end else begin
                check_val("to_pulse", 32'(timeout_err), 1);
                if (exp_retry < 15) exp_retry++;
            end
            check_val("to_retry", 32'(retry_count), 32'(exp_retry));
            check_val("to_pll_rst_up", 32'(pll_rst), 1);
            check_val("to_core", 32'(core_reset_n), 0);
            tick(3);
            check_val("to_pll_rst_hold", 32'(pll_rst), 1);
            check_val("to_pulse_end", 32'(timeout_err), 0);
            tick(1);
            check_val("to_pll_rst_fall", 32'(pll_rst), 0);
        end
        check_val("retry_saturated", 32'(retry_count), 15);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
